// File: rtl/blackjack_pkg.sv
// Shared types, limits and hand arithmetic helpers for the blackjack table.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package blackjack_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_CLEAR       = 4'd1,
    ST_DEAL        = 4'd2,
    ST_PEEK        = 4'd3,
    ST_PLAYER_TURN = 4'd4,
    ST_DEALER_TURN = 4'd5,
    ST_SETTLE      = 4'd6,
    ST_DONE        = 4'd7
  } table_state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_LOSE = 2'b01,
    RES_TIE  = 2'b10,
    RES_WIN  = 2'b11
  } result_t;

  typedef logic [3:0] card_value_t;
  typedef logic [4:0] hand_sum_t;

  localparam hand_sum_t BJ_LIMIT  = 5'd21;
  localparam hand_sum_t ACE_BONUS = 5'd10;

  // Face cards and out-of-range deck codes all count as ten.
  function automatic hand_sum_t card_points(card_value_t v);
    if (v == 4'd0 || v > 4'd10) begin
      return 5'd10;
    end
    return {1'b0, v};
  endfunction

  // Promote one ace to eleven when that does not bust the hand.
  function automatic hand_sum_t best_sum(hand_sum_t hard, logic ace);
    if (ace && hard <= (BJ_LIMIT - ACE_BONUS)) begin
      return hard + ACE_BONUS;
    end
    return hard;
  endfunction

endpackage

// File: rtl/blackjack_table_ctrl_hand_accum.sv
// Accumulates one hand: hard sum, ace flag, card count, best sum and softness.
// Latency: a card added in cycle t is reflected in all outputs from cycle t+1.
// Backpressure: none; the caller pulses i_add exactly once per consumed card.
module hand_accum
  import blackjack_pkg::*;
#(
  parameter int MAX_CARDS = 5,
  parameter int CNT_W     = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_add,
  input  card_value_t      i_card,
  output hand_sum_t        o_hard,
  output logic             o_ace,
  output logic [CNT_W-1:0] o_count,
  output hand_sum_t        o_best,
  output logic             o_soft
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CARDS);

  hand_sum_t        hard_q, hard_d;
  logic             ace_q, ace_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next hand contents: clear wins over add; count saturates at the hand limit.
  always_comb begin
    hard_d  = hard_q;
    ace_d   = ace_q;
    count_d = count_q;
    if (i_clear) begin
      hard_d  = '0;
      ace_d   = 1'b0;
      count_d = '0;
    end else if (i_add) begin
      hard_d = hard_q + card_points(i_card);
      if (i_card == 4'd1) begin
        ace_d = 1'b1;
      end
      if (count_q != MAX_CNT) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Hand state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hard_q  <= '0;
      ace_q   <= 1'b0;
      count_q <= '0;
    end else begin
      hard_q  <= hard_d;
      ace_q   <= ace_d;
      count_q <= count_d;
    end
  end

  assign o_hard  = hard_q;
  assign o_ace   = ace_q;
  assign o_count = count_q;
  assign o_best  = best_sum(hard_q, ace_q);
  assign o_soft  = (o_best != hard_q);

endmodule

// File: rtl/blackjack_table_ctrl.sv
// Runs a full blackjack round for NUM_PLAYERS seats against the dealer.
// Latency: one card per deck handshake; request drops the cycle after the card is taken.
// Backpressure: o_card_req holds until i_card_valid; the round simply waits on the deck.
module blackjack_table_ctrl
  import blackjack_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int MAX_CARDS    = 5,
  parameter int DEALER_STAND = 17,
  parameter int HIT_SOFT17   = 0,
  parameter int CHARLIE_EN   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_hit,
  input  logic                     i_stand,
  input  logic                     i_card_valid,
  input  logic [3:0]               i_card_value,
  output logic                     o_card_req,
  output logic [3:0]               o_state,
  output logic [1:0]               o_active_seat,
  output logic [5*NUM_PLAYERS-1:0] o_player_sums,
  output logic [4:0]               o_dealer_sum,
  output logic                     o_hole_hidden,
  output logic [2*NUM_PLAYERS-1:0] o_results,
  output logic                     o_round_done
);

  localparam int NH     = NUM_PLAYERS + 1;
  localparam int DLR    = NUM_PLAYERS;
  localparam int CNT_W  = $clog2(MAX_CARDS + 1);
  localparam int DEAL_W = 4;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CARDS);
  localparam logic [CNT_W-1:0]  TWO_CNT   = CNT_W'(2);
  localparam logic [DEAL_W-1:0] LAST_DEAL = DEAL_W'(2 * NH - 1);
  localparam hand_sum_t         STAND_SUM = hand_sum_t'(DEALER_STAND);

  table_state_t      state_q, state_d;
  logic [1:0]        seat_q, seat_d;
  logic [DEAL_W-1:0] deal_cnt_q, deal_cnt_d;
  logic              req_q, req_d;
  logic              hole_q, hole_d;
  hand_sum_t         up_q, up_d;
  result_t           results_q [NUM_PLAYERS];
  result_t           results_d [NUM_PLAYERS];

  hand_sum_t        hand_hard [NH];
  logic             hand_ace  [NH];
  logic [CNT_W-1:0] hand_cnt  [NH];
  hand_sum_t        hand_best [NH];
  logic             hand_soft [NH];
  logic             hand_add  [NH];
  logic             clear_hands;

  logic             take;
  int               deal_tgt;
  hand_sum_t        act_hard, act_best;
  logic [CNT_W-1:0] act_cnt;
  logic             dealer_bj, dealer_bust, adv, found, all_res;
  int               nxt;

  assign take        = req_q && i_card_valid;
  assign clear_hands = (state_q == ST_CLEAR);
  assign dealer_bj   = hand_ace[DLR] && hand_hard[DLR] == 5'd11 && hand_cnt[DLR] == TWO_CNT;
  assign dealer_bust = hand_hard[DLR] > BJ_LIMIT;

  for (genvar h = 0; h < NH; h++) begin : g_hand
    hand_accum #(
      .MAX_CARDS(MAX_CARDS),
      .CNT_W    (CNT_W)
    ) u_hand (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_clear(clear_hands),
      .i_add  (hand_add[h]),
      .i_card (i_card_value),
      .o_hard (hand_hard[h]),
      .o_ace  (hand_ace[h]),
      .o_count(hand_cnt[h]),
      .o_best (hand_best[h]),
      .o_soft (hand_soft[h])
    );
  end

  // Deal order is seat 0..N-1 then dealer, twice; map the deal counter to a hand.
  always_comb begin
    deal_tgt = int'(deal_cnt_q);
    if (deal_tgt >= NH) begin
      deal_tgt = deal_tgt - NH;
    end
  end

  // Steer a consumed card into exactly one hand based on the phase of the round.
  always_comb begin
    for (int h = 0; h < NH; h++) begin
      hand_add[h] = 1'b0;
      if (take) begin
        if (state_q == ST_DEAL && deal_tgt == h) begin
          hand_add[h] = 1'b1;
        end
        if (h < NUM_PLAYERS && state_q == ST_PLAYER_TURN && int'(seat_q) == h) begin
          hand_add[h] = 1'b1;
        end
        if (h == DLR && state_q == ST_DEALER_TURN) begin
          hand_add[h] = 1'b1;
        end
      end
    end
  end

  // Select the active seat's hand without indexing by a wider-than-needed pointer.
  always_comb begin
    act_hard = '0;
    act_best = '0;
    act_cnt  = '0;
    for (int s = 0; s < NUM_PLAYERS; s++) begin
      if (int'(seat_q) == s) begin
        act_hard = hand_hard[s];
        act_best = hand_best[s];
        act_cnt  = hand_cnt[s];
      end
    end
  end

  // Table FSM: next state, seat pointer, deck request, hole masking and results.
  always_comb begin
    state_d    = state_q;
    seat_d     = seat_q;
    deal_cnt_d = deal_cnt_q;
    req_d      = req_q;
    hole_d     = hole_q;
    up_d       = up_q;
    results_d  = results_q;
    adv        = 1'b0;
    found      = 1'b0;
    all_res    = 1'b1;
    nxt        = 0;

    if (take) begin
      req_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        for (int s = 0; s < NUM_PLAYERS; s++) begin
          results_d[s] = RES_NONE;
        end
        hole_d     = 1'b1;
        deal_cnt_d = '0;
        seat_d     = '0;
        up_d       = '0;
        req_d      = 1'b0;
        state_d    = ST_DEAL;
      end

      ST_DEAL: begin
        if (take) begin
          // The dealer's first-pass card is the only one shown while the hole is hidden.
          if (deal_tgt == DLR && int'(deal_cnt_q) < NH) begin
            up_d = card_points(i_card_value);
          end
          deal_cnt_d = deal_cnt_q + DEAL_W'(1);
          if (deal_cnt_q == LAST_DEAL) begin
            state_d = ST_PEEK;
          end
        end else if (!req_q) begin
          req_d = 1'b1;
        end
      end

      ST_PEEK: begin
        if (dealer_bj) begin
          hole_d = 1'b0;
          for (int s = 0; s < NUM_PLAYERS; s++) begin
            if (hand_ace[s] && hand_hard[s] == 5'd11 && hand_cnt[s] == TWO_CNT) begin
              results_d[s] = RES_TIE;
            end else begin
              results_d[s] = RES_LOSE;
            end
          end
          state_d = ST_SETTLE;
        end else begin
          for (int s = 0; s < NUM_PLAYERS; s++) begin
            if (hand_ace[s] && hand_hard[s] == 5'd11 && hand_cnt[s] == TWO_CNT) begin
              results_d[s] = RES_WIN;
            end
          end
          for (int s = NUM_PLAYERS - 1; s >= 0; s--) begin
            if (results_d[s] == RES_NONE) begin
              nxt   = s;
              found = 1'b1;
            end
          end
          if (found) begin
            seat_d  = 2'(nxt);
            state_d = ST_PLAYER_TURN;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_PLAYER_TURN: begin
        // Hand outputs already include any card taken last cycle, so the
        // automatic outcomes are checked whenever no request is in flight.
        if (!req_q) begin
          if (act_hard > BJ_LIMIT) begin
            adv = 1'b1;
            for (int s = 0; s < NUM_PLAYERS; s++) begin
              if (int'(seat_q) == s) begin
                results_d[s] = RES_LOSE;
              end
            end
          end else if (act_best == BJ_LIMIT) begin
            adv = 1'b1;
          end else if (act_cnt == MAX_CNT) begin
            adv = 1'b1;
            if (CHARLIE_EN != 0) begin
              for (int s = 0; s < NUM_PLAYERS; s++) begin
                if (int'(seat_q) == s) begin
                  results_d[s] = RES_WIN;
                end
              end
            end
          end else if (i_stand) begin
            adv = 1'b1;
          end else if (i_hit) begin
            req_d = 1'b1;
          end
        end

        if (adv) begin
          for (int s = NUM_PLAYERS - 1; s >= 0; s--) begin
            if (s > int'(seat_q) && results_d[s] == RES_NONE) begin
              nxt   = s;
              found = 1'b1;
            end
          end
          for (int s = 0; s < NUM_PLAYERS; s++) begin
            if (results_d[s] == RES_NONE) begin
              all_res = 1'b0;
            end
          end
          if (found) begin
            seat_d = 2'(nxt);
          end else if (all_res) begin
            state_d = ST_SETTLE;
          end else begin
            hole_d  = 1'b0;
            state_d = ST_DEALER_TURN;
          end
        end
      end

      ST_DEALER_TURN: begin
        hole_d = 1'b0;
        if (!req_q) begin
          if (hand_cnt[DLR] < MAX_CNT &&
              (hand_best[DLR] < STAND_SUM ||
               (HIT_SOFT17 != 0 && hand_best[DLR] == STAND_SUM && hand_soft[DLR]))) begin
            req_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        for (int s = 0; s < NUM_PLAYERS; s++) begin
          if (results_q[s] == RES_NONE) begin
            if (dealer_bust) begin
              results_d[s] = RES_WIN;
            end else if (CHARLIE_EN != 0 && hand_cnt[DLR] == MAX_CNT) begin
              results_d[s] = RES_LOSE;
            end else if (hand_best[s] > hand_best[DLR]) begin
              results_d[s] = RES_WIN;
            end else if (hand_best[s] == hand_best[DLR]) begin
              results_d[s] = RES_TIE;
            end else begin
              results_d[s] = RES_LOSE;
            end
          end
        end
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Table state registers; reset drops any outstanding deck request.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      seat_q     <= '0;
      deal_cnt_q <= '0;
      req_q      <= 1'b0;
      hole_q     <= 1'b0;
      up_q       <= '0;
      for (int s = 0; s < NUM_PLAYERS; s++) begin
        results_q[s] <= RES_NONE;
      end
    end else begin
      state_q    <= state_d;
      seat_q     <= seat_d;
      deal_cnt_q <= deal_cnt_d;
      req_q      <= req_d;
      hole_q     <= hole_d;
      up_q       <= up_d;
      results_q  <= results_d;
    end
  end

  // Pack per-seat sums and results, seat 0 in the least significant bits.
  always_comb begin
    o_player_sums = '0;
    o_results     = '0;
    for (int s = 0; s < NUM_PLAYERS; s++) begin
      o_player_sums[5*s +: 5] = hand_best[s];
      o_results[2*s +: 2]     = results_q[s];
    end
  end

  assign o_card_req    = req_q;
  assign o_state       = state_q;
  assign o_active_seat = seat_q;
  assign o_hole_hidden = hole_q;
  assign o_round_done  = (state_q == ST_DONE);
  assign o_dealer_sum  = hole_q ? best_sum(up_q, up_q == 5'd1) : hand_best[DLR];

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
module tb_blackjack_table_ctrl;
  import blackjack_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       start, hit, stand, card_valid;
  logic [3:0] card_value;
  logic       sel;

  logic       req_a, hole_a, done_a, req_b, hole_b, done_b;
  logic [3:0] st_a, st_b, res_a, res_b;
  logic [1:0] seat_a, seat_b;
  logic [9:0] psum_a, psum_b;
  logic [4:0] dsum_a, dsum_b;

  logic       cur_req, cur_hole, cur_done;
  logic [3:0] cur_state, cur_res;
  logic [1:0] cur_seat;
  logic [9:0] cur_psum;
  logic [4:0] cur_dsum;

  int checks = 0;
  int errors = 0;
  int pt_cnt_a = 0;
  int pt_before;

  always #5 i_clk = ~i_clk;

  blackjack_table_ctrl #(
    .NUM_PLAYERS(2), .MAX_CARDS(5), .DEALER_STAND(17), .HIT_SOFT17(0), .CHARLIE_EN(1)
  ) dut_a (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_start(start & ~sel), .i_hit(hit & ~sel), .i_stand(stand & ~sel),
    .i_card_valid(card_valid & ~sel), .i_card_value(card_value),
    .o_card_req(req_a), .o_state(st_a), .o_active_seat(seat_a),
    .o_player_sums(psum_a), .o_dealer_sum(dsum_a), .o_hole_hidden(hole_a),
    .o_results(res_a), .o_round_done(done_a)
  );

  blackjack_table_ctrl #(
    .NUM_PLAYERS(2), .MAX_CARDS(5), .DEALER_STAND(17), .HIT_SOFT17(1), .CHARLIE_EN(0)
  ) dut_b (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_start(start & sel), .i_hit(hit & sel), .i_stand(stand & sel),
    .i_card_valid(card_valid & sel), .i_card_value(card_value),
    .o_card_req(req_b), .o_state(st_b), .o_active_seat(seat_b),
    .o_player_sums(psum_b), .o_dealer_sum(dsum_b), .o_hole_hidden(hole_b),
    .o_results(res_b), .o_round_done(done_b)
  );

  assign cur_req   = sel ? req_b  : req_a;
  assign cur_hole  = sel ? hole_b : hole_a;
  assign cur_done  = sel ? done_b : done_a;
  assign cur_state = sel ? st_b   : st_a;
  assign cur_res   = sel ? res_b  : res_a;
  assign cur_seat  = sel ? seat_b : seat_a;
  assign cur_psum  = sel ? psum_b : psum_a;
  assign cur_dsum  = sel ? dsum_b : dsum_a;

  always @(posedge i_clk) begin
    if (st_a == ST_PLAYER_TURN) pt_cnt_a <= pt_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the deck request, then present one card for exactly one cycle.
  task automatic feed(input logic [3:0] v);
    int n = 0;
    while (!cur_req && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("feed_req", {31'd0, cur_req}, 32'd1);
    if (cur_req) begin
      card_valid = 1'b1;
      card_value = v;
      @(negedge i_clk);
      card_valid = 1'b0;
    end
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
    int n = 0;
    while (cur_state !== st && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, {28'd0, cur_state}, {28'd0, st});
  endtask

  task automatic pulse(input logic h, input logic s);
    hit   = h;
    stand = s;
    @(negedge i_clk);
    hit   = 1'b0;
    stand = 1'b0;
  endtask

  task automatic start_round();
    start = 1'b1;
    @(negedge i_clk);
    start = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0;
    card_valid = 1'b0; card_value = 4'd0; sel = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_state", cur_state, ST_IDLE);
    chk("rst_req", cur_req, 0);
    chk("rst_sums", cur_psum, 0);
    chk("rst_dsum", cur_dsum, 0);
    chk("rst_res", cur_res, 0);
    chk("rst_hole", cur_hole, 0);
    chk("rst_seat", cur_seat, 0);
    chk("rst_done", cur_done, 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Round 1: seat0 blackjack, seat1 17 vs dealer 17
    start_round();
    feed(4'd10); feed(4'd9); feed(4'd7); feed(4'd1); feed(4'd8); feed(4'd10);
    chk("r1_peek", cur_state, ST_PEEK);
    wait_state("r1_pturn", ST_PLAYER_TURN, 5);
    chk("r1_seat", cur_seat, 1);
    chk("r1_bjwin", cur_res, 4'b0011);
    chk("r1_hidden", cur_hole, 1);
    chk("r1_upcard", cur_dsum, 7);
    pulse(1'b0, 1'b1);
    wait_state("r1_done", ST_DONE, 20);
    chk("r1_res", cur_res, 4'b1011);
    chk("r1_psum", cur_psum, {5'd17, 5'd21});
    chk("r1_dsum", cur_dsum, 17);
    chk("r1_hole", cur_hole, 0);
    chk("r1_rdone", cur_done, 1);
    chk("r1_req", cur_req, 0);

    // Round 2: dealer blackjack at peek
    pt_before = pt_cnt_a;
    start_round();
    feed(4'd9); feed(4'd1); feed(4'd1); feed(4'd9); feed(4'd13); feed(4'd10);
    chk("r2_peek", cur_state, ST_PEEK);
    chk("r2_hidden", cur_hole, 1);
    chk("r2_upace", cur_dsum, 11);
    @(negedge i_clk);
    chk("r2_settle", cur_state, ST_SETTLE);
    chk("r2_reveal", cur_hole, 0);
    chk("r2_res", cur_res, 4'b1001);
    wait_state("r2_done", ST_DONE, 5);
    chk("r2_dsum", cur_dsum, 21);
    chk("r2_no_pturn", pt_cnt_a - pt_before, 0);

    // Round 3: five-card charlie on seat0
    start_round();
    feed(4'd2); feed(4'd10); feed(4'd10); feed(4'd3); feed(4'd7); feed(4'd8);
    wait_state("r3_pturn", ST_PLAYER_TURN, 5);
    chk("r3_seat0", cur_seat, 0);
    pulse(1'b1, 1'b0); feed(4'd2);
    chk("r3_sum7", cur_psum[4:0], 7);
    pulse(1'b1, 1'b0); feed(4'd4);
    pulse(1'b1, 1'b0); feed(4'd5);
    chk("r3_sum16", cur_psum[4:0], 16);
    @(negedge i_clk);
    chk("r3_charlie", cur_res, 4'b0011);
    chk("r3_adv", cur_seat, 1);
    pulse(1'b0, 1'b1);
    wait_state("r3_done", ST_DONE, 20);
    chk("r3_res", cur_res, 4'b0111);
    chk("r3_dsum", cur_dsum, 18);

    // Round 4 (second table, hit soft 17, charlie off)
    sel = 1'b1;
    @(negedge i_clk);
    start_round();
    feed(4'd2); feed(4'd10); feed(4'd1); feed(4'd3); feed(4'd7); feed(4'd6);
    wait_state("r4_pturn", ST_PLAYER_TURN, 5);
    chk("r4_upace", cur_dsum, 11);
    pulse(1'b1, 1'b0); feed(4'd2);
    pulse(1'b1, 1'b0); feed(4'd4);
    pulse(1'b1, 1'b0); feed(4'd5);
    @(negedge i_clk);
    chk("r4_nocharlie", cur_res, 0);
    chk("r4_adv", cur_seat, 1);
    chk("r4_sum16", cur_psum[4:0], 16);
    pulse(1'b0, 1'b1);
    for (int n = 0; n < 10 && !cur_req; n++) @(negedge i_clk);
    chk("r4_s17_req", cur_req, 1);
    chk("r4_dturn", cur_state, ST_DEALER_TURN);
    chk("r4_soft17", cur_dsum, 17);
    chk("r4_reveal", cur_hole, 0);
    feed(4'd5); feed(4'd6);
    wait_state("r4_done", ST_DONE, 20);
    chk("r4_dsum", cur_dsum, 18);
    chk("r4_res", cur_res, 4'b0101);
    sel = 1'b0;
    @(negedge i_clk);

    // Round 5: dealer soft 17 stands, deck stall, hit+stand together
    start_round();
    feed(4'd10); feed(4'd5); feed(4'd1); feed(4'd6); feed(4'd5); feed(4'd6);
    wait_state("r5_pturn", ST_PLAYER_TURN, 5);
    chk("r5_upace", cur_dsum, 11);
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      hit = (n % 4 == 1);
      @(negedge i_clk);
    end
    hit = 1'b0;
    chk("r5_stall_req", cur_req, 1);
    chk("r5_stall_state", cur_state, ST_PLAYER_TURN);
    chk("r5_stall_seat", cur_seat, 0);
    chk("r5_stall_sum", cur_psum[4:0], 16);
    feed(4'd5);
    chk("r5_sum21", cur_psum[4:0], 21);
    @(negedge i_clk);
    chk("r5_autostand", cur_seat, 1);
    chk("r5_res_none", cur_res, 0);
    pulse(1'b1, 1'b1);
    chk("r5_hs_state", cur_state, ST_DEALER_TURN);
    chk("r5_hs_noreq", cur_req, 0);
    wait_state("r5_done", ST_DONE, 10);
    chk("r5_dsum", cur_dsum, 17);
    chk("r5_res", cur_res, 4'b0111);
    chk("r5_psum", cur_psum, {5'd10, 5'd21});
    chk("r5_req", cur_req, 0);

    // Round 6: reset while the dealer waits on the deck
    start_round();
    feed(4'd10); feed(4'd10); feed(4'd5); feed(4'd8); feed(4'd9); feed(4'd6);
    wait_state("r6_pturn", ST_PLAYER_TURN, 5);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    for (int n = 0; n < 10 && !cur_req; n++) @(negedge i_clk);
    chk("r6_dreq", cur_req, 1);
    chk("r6_dturn", cur_state, ST_DEALER_TURN);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("r6_rst_state", cur_state, ST_IDLE);
    chk("r6_rst_req", cur_req, 0);
    chk("r6_rst_psum", cur_psum, 0);
    chk("r6_rst_dsum", cur_dsum, 0);
    chk("r6_rst_res", cur_res, 0);
    chk("r6_rst_hole", cur_hole, 0);
    i_reset = 1'b0;
    card_valid = 1'b1;
    card_value = 4'd5;
    repeat (2) @(negedge i_clk);
    card_valid = 1'b0;
    chk("r6_late_state", cur_state, ST_IDLE);
    chk("r6_late_req", cur_req, 0);
    chk("r6_late_dsum", cur_dsum, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
